// File: rtl/matmul_fifo_ctrl_if.sv
// Host/FIFO-side bundle of the matmul sequencer: command, element stream in,
// A/B FIFO write strobes and shift enable out. master = host, slave = sequencer.
interface matmul_fifo_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int BITS  = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                   start;
  logic                   abort;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [BITS-1:0] in_data;
  logic                   a_wren;
  logic                   b_wren;
  logic [AW-1:0]          wr_row;
  logic [AW-1:0]          wr_col;
  logic signed [BITS-1:0] wr_d;
  logic                   shift_en;
  logic                   busy;
  logic                   done;

  modport master (
    output start, abort, in_valid, in_data,
    input  in_ready, a_wren, b_wren, wr_row, wr_col,
    input  wr_d, shift_en, busy, done
  );

  modport slave (
    input  start, abort, in_valid, in_data,
    output in_ready, a_wren, b_wren, wr_row, wr_col,
    output wr_d, shift_en, busy, done
  );
endinterface

// File: rtl/matmul_fifo_ctrl.sv
// Matmul front-end sequencer: loads A then B row-major into the operand FIFOs,
// streams shift_en for STREAM_CYCLES, pulses done. Ports: clk, rst_n, bus (slave).
module matmul_fifo_ctrl #(
  parameter int DEPTH         = 8,
  parameter int BITS          = 8,
  parameter int STREAM_CYCLES = 3*DEPTH-2
) (
  input logic              clk,
  input logic              rst_n,
  matmul_fifo_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STREAM_CYCLES+1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);
  localparam logic [CW-1:0] SC_LAST = CW'(STREAM_CYCLES-1);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, SETTLE, STREAM, DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          row_q, row_d;
  logic [AW-1:0]          col_q, col_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   in_ready_q;
  logic                   busy_q;
  logic                   shift_q;
  logic                   done_q;
  logic                   a_wren_q;
  logic                   b_wren_q;
  logic [AW-1:0]          wr_row_q;
  logic [AW-1:0]          wr_col_q;
  logic signed [BITS-1:0] wr_d_q;
  logic                   accept;

  // in_ready_q is high only in the load states, so it doubles as the
  // accept qualifier; an accept in an abort cycle is still honoured.
  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    if (bus.abort) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          row_d = '0;
          col_d = '0;
          cnt_d = '0;
          if (bus.start) state_d = LOAD_A;
        end
        LOAD_A, LOAD_B: begin
          if (accept) begin
            if (col_q == LAST) begin
              col_d = '0;
              if (row_q == LAST) begin
                row_d   = '0;
                state_d = (state_q == LOAD_A) ? LOAD_B : SETTLE;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
        // One gap cycle so the final B write lands before any shift.
        SETTLE: begin
          state_d = STREAM;
          cnt_d   = '0;
        end
        STREAM: begin
          if (cnt_q == SC_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      shift_q    <= 1'b0;
      done_q     <= 1'b0;
      a_wren_q   <= 1'b0;
      b_wren_q   <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_d_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == LOAD_A) || (state_d == LOAD_B);
      busy_q     <= (state_d != IDLE);
      shift_q    <= (state_d == STREAM);
      done_q     <= (state_d == DONE);
      a_wren_q   <= accept && (state_q == LOAD_A);
      b_wren_q   <= accept && (state_q == LOAD_B);
      if (accept) begin
        wr_row_q <= row_q;
        wr_col_q <= col_q;
        wr_d_q   <= bus.in_data;
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.shift_en = shift_q;
  assign bus.done     = done_q;
  assign bus.a_wren   = a_wren_q;
  assign bus.b_wren   = b_wren_q;
  assign bus.wr_row   = wr_row_q;
  assign bus.wr_col   = wr_col_q;
  assign bus.wr_d     = wr_d_q;
endmodule

// File: doc/matmul_fifo_ctrl.md
# matmul_fifo_ctrl

Sequencer for the systolic matrix-multiply front end: accepts a start command, streams DEPTH×DEPTH operand elements for matrix A and then matrix B from a valid/ready input, and converts them into row/column write strobes for the two operand FIFOs. It then drives the shared shift enable for a fixed number of cycles to feed the array, and pulses `done`. It sits between the host load path and the A/B operand FIFOs, and is their only writer and shifter.

## Interface
- `DEPTH`, 8, matrix dimension and FIFO depth (power of two, ≥2)
- `BITS`, 8, signed element width
- `STREAM_CYCLES`, 3*DEPTH-2, number of `shift_en` cycles per multiply (≥1)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  begin a multiply; sampled only in IDLE
- `abort`  in  1  synchronous cancel; highest priority
- `in_valid`  in  1  input element valid
- `in_ready`  out  1  controller accepts an element this cycle
- `in_data`  in  BITS  signed element, row-major order, all of A then all of B
- `a_wren`  out  1  write strobe to A FIFO
- `b_wren`  out  1  write strobe to B FIFO
- `wr_row`  out  clog2(DEPTH)  row of the current write
- `wr_col`  out  clog2(DEPTH)  column of the current write
- `wr_d`  out  BITS  data of the current write
- `shift_en`  out  1  shift enable to both FIFOs
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE → LOAD_A → LOAD_B → SETTLE → STREAM → DONE → IDLE.
- IDLE: `in_ready`=0; `in_valid` is ignored. `start`=1 moves the FSM to LOAD_A on the next edge. The element counters (`row`, `col`) are cleared.
- LOAD_A / LOAD_B:
  - `in_ready`=1. An accept is `in_valid & in_ready`.
  - Each accept advances `col`. When `col` reaches DEPTH-1 it wraps to 0 and `row` increments.
  - The accept of element (DEPTH-1, DEPTH-1) changes state: LOAD_A→LOAD_B, or LOAD_B→SETTLE. The counters return to 0.
  - `in_valid` low stalls the load with no timeout. Counters and state hold.
- Writes are registered:
  - An accept at edge t produces `a_wren` or `b_wren`=1 in cycle t+1, with `wr_row`/`wr_col` equal to that element's indices and `wr_d`=`in_data`.
  - Exactly one of `a_wren`/`b_wren` is high per accept.
  - `wr_row`, `wr_col` and `wr_d` hold their last value when no strobe is high.
- SETTLE: lasts 1 cycle. `in_ready`=0. It guarantees the last `b_wren` never coincides with `shift_en`, because the FIFOs give writes priority over shifts.
- STREAM:
  - `shift_en`=1 for exactly STREAM_CYCLES consecutive cycles.
  - A cycle counter of width clog2(STREAM_CYCLES+1) counts them.
  - `in_ready`=0 throughout.
- DONE: lasts 1 cycle. `done`=1 and `busy`=1, then the FSM returns to IDLE.
- `start` while `busy`=1 is ignored and not queued.
- `abort`=1 in any state:
  - Next state is IDLE and the counters are cleared.
  - From the following cycle, all strobes, `shift_en`, `in_ready` and `busy` are 0 and no `done` is issued.
  - An accept registered in the abort cycle still produces its single write strobe next cycle.
  - If `abort` and `start` are asserted together in IDLE, `abort` wins.
- `abort`=1 in the same cycle as an accept: `in_ready` is still 1 in that cycle and the accept still happens.

## Timing
- Reset (`rst_n`=0, asynchronous) sets:
  - state to IDLE and all counters to 0;
  - `in_ready`, `a_wren`, `b_wren`, `shift_en`, `busy` and `done` to 0;
  - `wr_row`, `wr_col` and `wr_d` to 0.
- Reset assertion mid-operation takes effect immediately. No partial completion follows it.
- `start` at edge s: `busy`=1 and `in_ready`=1 from cycle s+1.
- Last B accept at edge t:
  - `b_wren` in cycle t+1 (state SETTLE);
  - `shift_en`=1 in cycles t+2 … t+1+STREAM_CYCLES;
  - `done`=1 in cycle t+2+STREAM_CYCLES;
  - `busy`=0 from t+3+STREAM_CYCLES.
- Minimum start-to-done with `in_valid` held high: 2·DEPTH² + STREAM_CYCLES + 2 cycles.
- A new `start` can be taken in the first IDLE cycle after `done`.

## Test plan
Directed scenarios use DEPTH=4, BITS=8, STREAM_CYCLES=10.
- **Reset:** assert `rst_n`=0 mid-STREAM → all outputs 0 asynchronously; after release, `start` runs a full clean pass.
- **Back-to-back load:**
  - Stimulus: `start`, then 32 elements with `in_valid` held high, values 1..32.
  - Writes: `a_wren` ×16 with (row, col) = (0,0)…(3,3) and `wr_d`=1..16, then `b_wren` ×16 with `wr_d`=17..32.
  - Stream and completion: one gap cycle, `shift_en` high exactly 10 cycles, then `done` for 1 cycle.
  - Total from `start` to `done`: 44 cycles.
- **Stalls:** toggle `in_valid` at random during both loads → exactly 32 strobes in order; counters hold during stalls; `in_data` values -128 and 127 pass through unchanged.
- **Start ignored:** pulse `start` during LOAD_B and during STREAM → no restart; one `done` only; `busy` stays 1.
- **Abort:**
  - `abort` in LOAD_A after 5 accepts → `busy`=0 next cycle, no `done`.
  - A following `start` writes A beginning at (0,0).
  - `abort` in the 4th STREAM cycle → `shift_en` low next cycle, no `done`.
- **Overlap check:** with `in_valid` held high, the last `b_wren` and the first `shift_en` are never asserted in the same cycle; `a_wren` and `b_wren` are never asserted together.
